// File: rtl/mips_mem_access_unit.sv
// Purpose : data-memory initiator for MIPS loads/stores; lane select + extension for
//           loads, read-modify-write for sb/sh (memory has no byte enables).
// Latency : start->done 2 cycles (lw/sw), 3 cycles (sb/sh), +1 per mem_ack wait cycle;
//           misaligned/unknown opcode completes the next cycle with error.
// Backpressure: mem_req held until mem_ack or TIMEOUT cycles; start ignored unless IDLE.
//
// Ports:
//   clk, reset                 clock, async active-high reset
//   start/opcode/address/write_data   request from execute stage (sampled in IDLE)
//   busy, done, error, read_data       status and extended load result to write-back
//   mem_req/mem_we/mem_addr/mem_wdata  registered word request to data memory
//   mem_ack/mem_rdata                  memory response
module mips_mem_access_unit #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [5:0]        opcode,
    input  logic [ADDR_W-1:0] address,
    input  logic [31:0]       write_data,
    output logic              busy,
    output logic              done,
    output logic [31:0]       read_data,
    output logic              error,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata
);

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic               ld_q, ld_d;        // 1 = load, 0 = store
    logic [1:0]         size_q, size_d;
    logic               sext_q, sext_d;
    logic [1:0]         lane_q, lane_d;    // address[1:0] of the access
    logic [15:0]        wlo_q, wlo_d;      // low half of rt, enough for sb/sh merge
    logic               err_q, err_d;
    logic               req_q, req_d;
    logic               we_q, we_d;
    logic [ADDR_W-3:0]  maddr_q, maddr_d;
    logic [31:0]        mwdata_q, mwdata_d;
    logic [31:0]        rdata_q, rdata_d;
    logic [7:0]         cnt_q, cnt_d;

    // Opcode decode of the live inputs, only used when a start is accepted.
    logic       dec_legal;
    logic       dec_load;
    logic [1:0] dec_size;
    logic       dec_sext;
    logic       dec_misal;

    always_comb begin
        dec_legal = 1'b1;
        dec_load  = 1'b0;
        dec_size  = SZ_W;
        dec_sext  = 1'b0;
        case (opcode)
            OP_LB:   begin dec_load = 1'b1; dec_size = SZ_B; dec_sext = 1'b1; end
            OP_LH:   begin dec_load = 1'b1; dec_size = SZ_H; dec_sext = 1'b1; end
            OP_LW:   begin dec_load = 1'b1; dec_size = SZ_W; end
            OP_LBU:  begin dec_load = 1'b1; dec_size = SZ_B; end
            OP_LHU:  begin dec_load = 1'b1; dec_size = SZ_H; end
            OP_SB:   dec_size = SZ_B;
            OP_SH:   dec_size = SZ_H;
            OP_SW:   dec_size = SZ_W;
            default: dec_legal = 1'b0;
        endcase
        dec_misal = ((dec_size == SZ_H) && address[0]) ||
                    ((dec_size == SZ_W) && (address[1:0] != 2'b00));
    end

    // Lane extraction / extension of the returned word for loads.
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_ext;

    always_comb begin
        case (lane_q)
            2'd0:    byte_sel = mem_rdata[7:0];
            2'd1:    byte_sel = mem_rdata[15:8];
            2'd2:    byte_sel = mem_rdata[23:16];
            default: byte_sel = mem_rdata[31:24];
        endcase
        half_sel = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (size_q)
            SZ_B:    load_ext = sext_q ? {{24{byte_sel[7]}}, byte_sel} : {24'd0, byte_sel};
            SZ_H:    load_ext = sext_q ? {{16{half_sel[15]}}, half_sel} : {16'd0, half_sel};
            default: load_ext = mem_rdata;
        endcase
    end

    // Sub-word store: splice rt's low byte/half into the word just read.
    logic [31:0] merged;

    always_comb begin
        merged = mem_rdata;
        if (size_q == SZ_B) begin
            case (lane_q)
                2'd0:    merged[7:0]   = wlo_q[7:0];
                2'd1:    merged[15:8]  = wlo_q[7:0];
                2'd2:    merged[23:16] = wlo_q[7:0];
                default: merged[31:24] = wlo_q[7:0];
            endcase
        end else if (lane_q[1]) begin
            merged[31:16] = wlo_q;
        end else begin
            merged[15:0] = wlo_q;
        end
    end

    logic [7:0] cnt_inc;
    assign cnt_inc = cnt_q + 8'd1;

    always_comb begin
        state_d  = state_q;
        ld_d     = ld_q;
        size_d   = size_q;
        sext_d   = sext_q;
        lane_d   = lane_q;
        wlo_d    = wlo_q;
        err_d    = err_q;
        req_d    = req_q;
        we_d     = we_q;
        maddr_d  = maddr_q;
        mwdata_d = mwdata_q;
        rdata_d  = rdata_q;
        cnt_d    = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    ld_d    = dec_load;
                    size_d  = dec_size;
                    sext_d  = dec_sext;
                    lane_d  = address[1:0];
                    wlo_d   = write_data[15:0];
                    maddr_d = address[ADDR_W-1:2];
                    cnt_d   = 8'd0;
                    if (!dec_legal || dec_misal) begin
                        // Rejected without touching memory.
                        state_d = S_DONE;
                        err_d   = 1'b1;
                    end else if (!dec_load && (dec_size == SZ_W)) begin
                        state_d  = S_WR;
                        err_d    = 1'b0;
                        req_d    = 1'b1;
                        we_d     = 1'b1;
                        mwdata_d = write_data;
                    end else begin
                        // Loads and sb/sh both start with a read.
                        state_d = S_RD;
                        err_d   = 1'b0;
                        req_d   = 1'b1;
                        we_d    = 1'b0;
                    end
                end
            end

            S_RD: begin
                if (mem_ack) begin
                    if (ld_q) begin
                        rdata_d = load_ext;
                        state_d = S_DONE;
                        req_d   = 1'b0;
                    end else begin
                        mwdata_d = merged;
                        we_d     = 1'b1;
                        cnt_d    = 8'd0;
                        state_d  = S_WR;
                    end
                end else if (cnt_inc == TIMEOUT_C) begin
                    state_d = S_DONE;
                    err_d   = 1'b1;
                    req_d   = 1'b0;
                    cnt_d   = cnt_inc;
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            S_WR: begin
                if (mem_ack) begin
                    state_d = S_DONE;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                end else if (cnt_inc == TIMEOUT_C) begin
                    state_d = S_DONE;
                    err_d   = 1'b1;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    cnt_d   = cnt_inc;
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            default: begin
                // DONE lasts one cycle; a start seen here is dropped.
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            ld_q     <= 1'b0;
            size_q   <= SZ_B;
            sext_q   <= 1'b0;
            lane_q   <= 2'd0;
            wlo_q    <= 16'd0;
            err_q    <= 1'b0;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            maddr_q  <= '0;
            mwdata_q <= 32'd0;
            rdata_q  <= 32'd0;
            cnt_q    <= 8'd0;
        end else begin
            state_q  <= state_d;
            ld_q     <= ld_d;
            size_q   <= size_d;
            sext_q   <= sext_d;
            lane_q   <= lane_d;
            wlo_q    <= wlo_d;
            err_q    <= err_d;
            req_q    <= req_d;
            we_q     <= we_d;
            maddr_q  <= maddr_d;
            mwdata_q <= mwdata_d;
            rdata_q  <= rdata_d;
            cnt_q    <= cnt_d;
        end
    end

    assign busy      = (state_q == S_RD) || (state_q == S_WR);
    assign done      = (state_q == S_DONE);
    assign error     = done && err_q;
    assign read_data = rdata_q;
    assign mem_req   = req_q;
    assign mem_we    = we_q;
    assign mem_addr  = maddr_q;
    assign mem_wdata = mwdata_q;

endmodule

// File: tb/tb_mips_mem_access_unit.sv
// Purpose : directed bench for mips_mem_access_unit with a behavioural word memory.
// Latency : memory acks after a programmable number of wait cycles (or never).
// Backpressure: responder holds mem_ack low for ack_delay request cycles.
module tb_mips_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [5:0]  opcode = 6'd0;
    logic [31:0] address = 32'd0;
    logic [31:0] write_data = 32'd0;
    logic        busy, done, error, mem_req, mem_we;
    logic [31:0] read_data, mem_wdata;
    logic [29:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'd0;

    mips_mem_access_unit #(.ADDR_W(32), .TIMEOUT(255)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .opcode     (opcode),
        .address    (address),
        .write_data (write_data),
        .busy       (busy),
        .done       (done),
        .read_data  (read_data),
        .error      (error),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Behavioural memory / responder, evaluated on the falling edge.
    logic [31:0] mem [0:63];
    int          ack_delay = 0;
    bit          ack_off = 1'b0;
    int          wcnt = 0;
    int          req_cycles = 0;
    int          nwrites = 0;
    int          unstable = 0;
    logic [31:0] last_wdata = 32'd0;
    logic [29:0] last_waddr = 30'd0;
    bit          held = 1'b0;
    logic        h_we;
    logic [29:0] h_addr;
    logic [31:0] h_wd;

    always @(negedge clk) begin
        if (mem_req && !reset) begin
            req_cycles++;
            if (held && (mem_we !== h_we || mem_addr !== h_addr || mem_wdata !== h_wd))
                unstable++;
            if (!ack_off && wcnt >= ack_delay) begin
                mem_ack   = 1'b1;
                mem_rdata = mem[mem_addr[5:0]];
                if (mem_we) begin
                    mem[mem_addr[5:0]] = mem_wdata;
                    nwrites++;
                    last_wdata = mem_wdata;
                    last_waddr = mem_addr;
                end
                wcnt = 0;
                held = 1'b0;
            end else begin
                mem_ack = 1'b0;
                wcnt++;
                held   = 1'b1;
                h_we   = mem_we;
                h_addr = mem_addr;
                h_wd   = mem_wdata;
            end
        end else begin
            mem_ack = 1'b0;
            wcnt    = 0;
            held    = 1'b0;
        end
    end

    task automatic go(input logic [5:0] op, input logic [31:0] a, input logic [31:0] wd);
        @(negedge clk);
        opcode     = op;
        address    = a;
        write_data = wd;
        start      = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Returns start-to-done latency in cycles (accept edge counts as cycle 1).
    task automatic wait_done(output int lat);
        int n;
        n = 0;
        while (!done && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("done_seen", {31'd0, done}, 32'd1);
        lat = n + 1;
    endtask

    task automatic run(input logic [5:0] op, input logic [31:0] a, input logic [31:0] wd,
                       output int lat, output logic [31:0] rd, output logic er);
        go(op, a, wd);
        wait_done(lat);
        rd = read_data;
        er = error;
        @(posedge clk);
        #1;
        check("done_pulse", {31'd0, done}, 32'd0);
    endtask

    typedef struct {
        logic [5:0]  op;
        logic [31:0] addr;
        logic [31:0] exp;
    } ld_vec_t;

    ld_vec_t     lv [7];
    int          lat;
    logic [31:0] rd;
    logic        er;
    int          rc0;
    int          nw0;
    logic        acc;

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy",  {31'd0, busy},    32'd0);
        check("rst_done",  {31'd0, done},    32'd0);
        check("rst_req",   {31'd0, mem_req}, 32'd0);
        check("rst_rdata", read_data,        32'd0);
        @(negedge clk);
        reset = 1'b0;
        check("rst_out", {mem_wdata[1:0], mem_addr[0], mem_we, error}, 32'd0);

        // Loads from word 0x10 = 0x8070_F0A5
        mem[16] = 32'h8070_F0A5;
        lv[0] = '{6'h20, 32'h41, 32'hFFFF_FFF0};   // lb lane 1
        lv[1] = '{6'h24, 32'h41, 32'h0000_00F0};   // lbu lane 1
        lv[2] = '{6'h25, 32'h42, 32'h0000_8070};   // lhu upper half
        lv[3] = '{6'h21, 32'h42, 32'hFFFF_8070};   // lh upper half
        lv[4] = '{6'h20, 32'h40, 32'hFFFF_FFA5};   // lb lane 0
        lv[5] = '{6'h24, 32'h43, 32'h0000_0080};   // lbu lane 3
        lv[6] = '{6'h21, 32'h40, 32'hFFFF_F0A5};   // lh lower half
        for (int i = 0; i < 7; i++) begin
            run(lv[i].op, lv[i].addr, 32'h0, lat, rd, er);
            check($sformatf("load%0d_data", i), rd, lv[i].exp);
            check($sformatf("load%0d_err", i), {31'd0, er}, 32'd0);
        end
        run(6'h23, 32'h40, 32'h0, lat, rd, er);
        check("lw_data", rd, 32'h8070_F0A5);
        check("lw_lat", lat, 32'd2);

        // sb read-modify-write
        mem[16] = 32'h1122_3344;
        nw0 = nwrites;
        run(6'h28, 32'h43, 32'h0000_0033, lat, rd, er);
        check("sb_lat",    lat,              32'd3);
        check("sb_wdata",  last_wdata,       32'h3322_3344);
        check("sb_nwr",    nwrites - nw0,    32'd1);
        check("sb_rdata",  rd,               32'h8070_F0A5);
        check("sb_err",    {31'd0, er},      32'd0);

        // sh into upper half of the same word
        run(6'h29, 32'h42, 32'h1234_BEEF, lat, rd, er);
        check("sh_mem", mem[16], 32'hBEEF_3344);
        check("sh_lat", lat, 32'd3);

        // sw with 4 wait cycles
        ack_delay = 4;
        rc0 = req_cycles;
        unstable = 0;
        run(6'h2B, 32'h08, 32'hCAFE_F00D, lat, rd, er);
        check("sw_lat",    lat,                32'd6);
        check("sw_addr",   {2'b00, last_waddr}, 32'h2);
        check("sw_mem",    mem[2],             32'hCAFE_F00D);
        check("sw_stable", unstable,           32'd0);
        check("sw_reqcyc", req_cycles - rc0,   32'd5);
        check("sw_err",    {31'd0, er},        32'd0);
        ack_delay = 0;

        // Misaligned / unknown opcodes: no memory traffic, error next cycle
        rc0 = req_cycles;
        run(6'h23, 32'h06, 32'h0, lat, rd, er);
        check("mis_lw_lat", lat, 32'd1);
        check("mis_lw_err", {31'd0, er}, 32'd1);
        run(6'h3F, 32'h40, 32'h0, lat, rd, er);
        check("badop_err", {31'd0, er}, 32'd1);
        run(6'h29, 32'h41, 32'h0, lat, rd, er);
        check("mis_sh_err", {31'd0, er}, 32'd1);
        check("mis_noreq", req_cycles - rc0, 32'd0);
        check("mis_rdata", rd, 32'h8070_F0A5);

        // Timeout: no ack ever
        ack_off = 1'b1;
        rc0 = req_cycles;
        run(6'h23, 32'h40, 32'h0, lat, rd, er);
        check("to_lat",    lat,              32'd256);
        check("to_reqcyc", req_cycles - rc0, 32'd255);
        check("to_err",    {31'd0, er},      32'd1);
        check("to_rdata",  rd,               32'h8070_F0A5);
        check("to_req",    {31'd0, mem_req}, 32'd0);

        // Reset in the middle of an RD wait
        go(6'h23, 32'h40, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        check("pre_rst_req", {30'd0, busy, mem_req}, 32'd3);
        #3 reset = 1'b1;
        #1;
        check("arst_req",  {31'd0, mem_req}, 32'd0);
        check("arst_busy", {31'd0, busy},    32'd0);
        check("arst_done", {31'd0, done},    32'd0);
        @(negedge clk);
        reset   = 1'b0;
        ack_off = 1'b0;
        acc = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1 acc = acc | done;
        end
        check("arst_nodone", {31'd0, acc}, 32'd0);
        check("arst_rdata", read_data, 32'd0);
        run(6'h23, 32'h40, 32'h0, lat, rd, er);
        check("post_rst_lw", rd, 32'hBEEF_3344);
        check("post_rst_lat", lat, 32'd2);

        // start while in DONE is dropped
        go(6'h23, 32'h40, 32'h0);
        wait_done(lat);
        nw0 = nwrites;
        go(6'h2B, 32'h00, 32'h1234_5678);
        acc = 1'b0;
        for (int i = 0; i < 5; i++) begin
            acc = acc | busy | mem_req | done;
            @(posedge clk);
            #1;
        end
        check("done_start_ign", {31'd0, acc}, 32'd0);
        check("done_start_mem", mem[0], 32'h0);
        check("done_start_nwr", nwrites - nw0, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mips_mem_access_unit.md
Name: mips_mem_access_unit

Overview:
- Initiator side of the data-memory port: turns a MIPS load/store issued by the execute stage into word-wide memory requests.
- Performs byte-lane selection and sign/zero extension for loads.
- Performs read-modify-write for sub-word stores, because the data memory has no byte enables.
- Sits between the ALU result / rt path and the data memory; returns read data to the write-back mux.

Parameters:
- ADDR_W, 32, width of the byte address from the ALU.
- TIMEOUT, 255, maximum cycles to wait for mem_ack before aborting with error (8-bit counter; legal range 1..255).

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request from execute stage; sampled only in IDLE.
- opcode  input  6  MIPS opcode: 0x20 lb, 0x21 lh, 0x23 lw, 0x24 lbu, 0x25 lhu, 0x28 sb, 0x29 sh, 0x2B sw.
- address  input  ADDR_W  byte address (ALU result).
- write_data  input  32  rt contents for stores.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle completion pulse.
- read_data  output  32  extended load result; valid while done=1, held until the next load completes.
- error  output  1  valid with done: misaligned access, unknown opcode or timeout.
- mem_req  output  1  memory request, held until acknowledged.
- mem_we  output  1  1 = write, 0 = read; stable while mem_req=1.
- mem_addr  output  ADDR_W-2  word address = address[ADDR_W-1:2]; stable while mem_req=1.
- mem_wdata  output  32  write word; stable while mem_req=1.
- mem_ack  input  1  responder accepts (write) or returns data (read) this cycle.
- mem_rdata  input  32  read word; valid when mem_ack=1 and mem_we=0.

Behaviour:
- Reset (async): state IDLE, all outputs 0, read_data 0, timeout counter 0. A reset mid-transaction drops mem_req immediately and no done is produced.
- Latched at start: opcode, address, write_data. Inputs are ignored after acceptance.
- Lanes are little-endian: lane n = bits [8n+7:8n]; byte lane = address[1:0]; half lane = address[1] (bits [15:0] or [31:16]).
- Alignment: lh/lhu/sh require address[0]=0; lw/sw require address[1:0]=0.
- Misaligned access or unknown opcode: state goes to DONE with error=1; no mem_req is issued.
- FSM states: IDLE, RD, WR, DONE.
- IDLE→RD: any legal load, sb or sh. IDLE→WR: sw.
- RD: mem_req=1, mem_we=0. On mem_ack, mem_rdata is captured.
  - Load: extend the selected lane → read_data; go to DONE.
  - sb/sh: merge write_data[7:0] or [15:0] into the selected lane of the captured word → mem_wdata; go to WR.
- WR: mem_req=1, mem_we=1. On mem_ack go to DONE. read_data is unchanged by stores.
- DONE: done=1 for exactly one cycle, busy=0, then IDLE. A start in DONE is ignored; start is accepted again from the next IDLE cycle.
- mem_req, mem_we, mem_addr and mem_wdata are registered. mem_req rises the cycle after start is accepted.
- Minimum latency, start to done, with mem_ack returned in the first request cycle:
  - lw/sw: 2 cycles.
  - sb/sh: 3 cycles.
  - Each wait cycle adds 1.
- Extension: lb/lh sign-extend; lbu/lhu zero-extend.
- Timeout: the counter clears on entering RD or WR and increments each cycle mem_req=1 without mem_ack. When it reaches TIMEOUT, mem_req drops, state goes to DONE, error=1, and read_data keeps its previous value.
- mem_ack while mem_req=0 is ignored. mem_ack on the same edge the counter hits TIMEOUT counts as success.
- start is ignored while busy or in DONE; no queuing.

Test Plan:
- mem word 0x10 = 0x8070_F0A5. lb with address 0x41 (word 0x10, lane 1) → read_data 0xFFFF_FFF0. lbu at the same address → 0x0000_00F0. lhu with address 0x42 → 0x0000_8070.
- sb write_data 0x0000_0033, address 0x43, memory holds 0x1122_3344. Expect an RD then a WR with mem_wdata 0x3322_3344; done 3 cycles after start with zero-wait ack.
- sw address 0x08, mem_ack delayed 4 cycles. Expect mem_req, mem_addr 0x02 and mem_wdata held stable through the wait; done exactly once; error=0.
- lw address 0x06 → no mem_req, done on the next cycle, error=1. opcode 0x3F → same.
- lw with mem_ack never asserted, TIMEOUT=255 → mem_req drops after 255 cycles, done with error=1, read_data unchanged.
- reset asserted in the RD wait → mem_req, busy and done go 0 asynchronously. A new lw after reset completes normally; a start pulse in DONE is ignored.
